usart_tx_fifo: RTL and testbench

//  Byte buffer and drain sequencer placed directly upstream of the usart transmitter.

---
 rtl/usart_tx_fifo_pkg.sv | 13 +
 rtl/usart_tx_fifo_if.sv | 28 ++
 rtl/usart_tx_fifo_mem.sv | 24 ++
 rtl/usart_tx_fifo.sv | 119 +++++++++++
 tb/tb_usart_tx_fifo.sv | 367 ++++++++++++++++++++++++++++++++++++
 5 files changed

// File: rtl/usart_tx_fifo_pkg.sv
// Shared defaults and FSM encoding for the usart transmit FIFO.
// Imported by the interface, the top and the storage sub-module.
package usart_tx_fifo_pkg;
    localparam int DATA_W_DEF      = 8;
    localparam int DEPTH_DEF       = 16;
    localparam int ACK_TIMEOUT_DEF = 15;

    typedef enum logic [1:0] {
        ST_IDLE      = 2'd0,
        ST_WAIT_ACK  = 2'd1,
        ST_WAIT_DONE = 2'd2
    } tx_state_e;
endpackage

// File: rtl/usart_tx_fifo_if.sv
// Producer push port, FIFO status and transmitter start/ready handshake.
// The FIFO is the slave side; producer and transmitter together form the master side.
interface usart_tx_fifo_if
    import usart_tx_fifo_pkg::*;
#(
    parameter int DATA_W = DATA_W_DEF,
    parameter int ADDR_W = $clog2(DEPTH_DEF)
);
    logic              wr_en;
    logic [DATA_W-1:0] wr_data;
    logic              full;
    logic              empty;
    logic [ADDR_W:0]   count;
    logic              overflow;
    logic [DATA_W-1:0] tx_data;
    logic              tx_start;
    logic              tx_ready;

    modport slave (
        input  wr_en, wr_data, tx_ready,
        output full, empty, count, overflow, tx_data, tx_start
    );

    modport master (
        output wr_en, wr_data, tx_ready,
        input  full, empty, count, overflow, tx_data, tx_start
    );
endinterface

// File: rtl/usart_tx_fifo_mem.sv
// FIFO storage (sync_fifo_mem): DEPTH x DATA_W registers, one write port,
// asynchronous read so the popped byte is available in the same cycle as the pop.
module usart_tx_fifo_mem
    import usart_tx_fifo_pkg::*;
#(
    parameter int DATA_W = DATA_W_DEF,
    parameter int DEPTH  = DEPTH_DEF,
    parameter int ADDR_W = $clog2(DEPTH)
) (
    input  logic              clk_i,
    input  logic              we_i,
    input  logic [ADDR_W-1:0] waddr_i,
    input  logic [DATA_W-1:0] wdata_i,
    input  logic [ADDR_W-1:0] raddr_i,
    output logic [DATA_W-1:0] rdata_o
);
    logic [DATA_W-1:0] mem_q [DEPTH];

    always_ff @(posedge clk_i) begin
        if (we_i) mem_q[waddr_i] <= wdata_i;
    end

    assign rdata_o = mem_q[raddr_i];
endmodule

// File: rtl/usart_tx_fifo.sv
// Byte FIFO in front of the usart transmitter: buffers producer pushes and
// drains them one at a time over a start/ready handshake, re-issuing ignored starts.
module usart_tx_fifo
    import usart_tx_fifo_pkg::*;
#(
    parameter int DATA_W      = DATA_W_DEF,
    parameter int DEPTH       = DEPTH_DEF,
    parameter int ADDR_W      = $clog2(DEPTH),
    parameter int ACK_TIMEOUT = ACK_TIMEOUT_DEF
) (
    input  logic            clk_i,
    input  logic            rst_ni,
    usart_tx_fifo_if.slave  bus
);
    localparam int              TMO_W    = $clog2(ACK_TIMEOUT + 1);
    localparam logic [ADDR_W:0] DEPTH_C  = (ADDR_W + 1)'(DEPTH);
    localparam logic [TMO_W-1:0] TMO_LAST = TMO_W'(ACK_TIMEOUT - 1);

    tx_state_e         state_q, state_d;
    logic [ADDR_W-1:0] wr_ptr_q, wr_ptr_d, rd_ptr_q, rd_ptr_d;
    logic [ADDR_W:0]   count_q, count_d;
    logic              ovf_q, ovf_d;
    logic [DATA_W-1:0] tx_data_q, tx_data_d, rd_data;
    logic              tx_start_q, tx_start_d;
    logic [TMO_W-1:0]  tmo_q, tmo_d;
    logic              full, empty, push, pop;

    assign full  = (count_q == DEPTH_C);
    assign empty = (count_q == '0);
    assign push  = bus.wr_en && !full;

    usart_tx_fifo_mem #(.DATA_W(DATA_W), .DEPTH(DEPTH), .ADDR_W(ADDR_W)) u_mem (
        .clk_i   (clk_i),
        .we_i    (push),
        .waddr_i (wr_ptr_q),
        .wdata_i (bus.wr_data),
        .raddr_i (rd_ptr_q),
        .rdata_o (rd_data)
    );

    always_comb begin
        wr_ptr_d = wr_ptr_q + ADDR_W'(push);
        rd_ptr_d = rd_ptr_q + ADDR_W'(pop);
        ovf_d    = ovf_q | (bus.wr_en & full);
        case ({push, pop})
            2'b10:   count_d = count_q + 1'b1;
            2'b01:   count_d = count_q - 1'b1;
            default: count_d = count_q;
        endcase
    end

    always_ff @(posedge clk_i or negedge rst_ni) begin
        if (!rst_ni) begin
            state_q    <= ST_IDLE;
            wr_ptr_q   <= '0;
            rd_ptr_q   <= '0;
            count_q    <= '0;
            ovf_q      <= 1'b0;
            tx_data_q  <= '0;
            tx_start_q <= 1'b0;
            tmo_q      <= '0;
        end else begin
            state_q    <= state_d;
            wr_ptr_q   <= wr_ptr_d;
            rd_ptr_q   <= rd_ptr_d;
            count_q    <= count_d;
            ovf_q      <= ovf_d;
            tx_data_q  <= tx_data_d;
            tx_start_q <= tx_start_d;
            tmo_q      <= tmo_d;
        end
    end

    always_comb begin
        state_d = state_q;
        case (state_q)
            ST_IDLE:      if (!empty && bus.tx_ready) state_d = ST_WAIT_ACK;
            ST_WAIT_ACK:  if (!bus.tx_ready)          state_d = ST_WAIT_DONE;
            ST_WAIT_DONE: if (bus.tx_ready)           state_d = ST_IDLE;
            default:                                  state_d = ST_IDLE;
        endcase
    end

    // tx_data only moves on a pop, so a re-issued start resends the same byte.
    always_comb begin
        pop        = 1'b0;
        tx_data_d  = tx_data_q;
        tx_start_d = 1'b0;
        tmo_d      = tmo_q;
        case (state_q)
            ST_IDLE: begin
                if (!empty && bus.tx_ready) begin
                    pop        = 1'b1;
                    tx_data_d  = rd_data;
                    tx_start_d = 1'b1;
                    tmo_d      = '0;
                end
            end
            ST_WAIT_ACK: begin
                if (bus.tx_ready) begin
                    if (tmo_q == TMO_LAST) begin
                        tx_start_d = 1'b1;
                        tmo_d      = '0;
                    end else begin
                        tmo_d = tmo_q + 1'b1;
                    end
                end
            end
            default: ;
        endcase
    end

    assign bus.full     = full;
    assign bus.empty    = empty;
    assign bus.count    = count_q;
    assign bus.overflow = ovf_q;
    assign bus.tx_data  = tx_data_q;
    assign bus.tx_start = tx_start_q;
endmodule

// File: tb/tb_usart_tx_fifo.sv
// Directed bench for usart_tx_fifo with a simple busy-for-N-cycles transmitter model.
module tb_usart_tx_fifo;
    logic clk = 1'b0;
    logic rst_n = 1'b1;
    int   checks = 0;
    int   passed = 0;

    logic model_en = 1'b0;
    logic model_ready = 1'b1;
    logic man_ready = 1'b0;
    int   busy_len = 100;
    int   busy_cnt = 0;
    int   viol = 0;
    int   dbl = 0;
    logic prev_start = 1'b0;
    logic [7:0] rx_q[$];

    usart_tx_fifo_if #(.DATA_W(8), .ADDR_W(4)) bus ();

    usart_tx_fifo dut (
        .clk_i  (clk),
        .rst_ni (rst_n),
        .bus    (bus)
    );

    always #5 clk = ~clk;

    assign bus.tx_ready = model_en ? model_ready : man_ready;

    // Transmitter model: accepts a start, drops ready for busy_len cycles.
    always @(posedge clk) begin
        prev_start <= bus.tx_start;
        if (prev_start && bus.tx_start) dbl <= dbl + 1;
        if (model_en) begin
            if (bus.tx_start) begin
                if (!model_ready) viol <= viol + 1;
                rx_q.push_back(bus.tx_data);
                model_ready <= 1'b0;
                busy_cnt    <= busy_len;
            end else if (busy_cnt > 0) begin
                busy_cnt <= busy_cnt - 1;
                if (busy_cnt == 1) model_ready <= 1'b1;
            end
        end
    end

    task automatic wait_model_idle();
        int n = 0;
        while (!(model_ready && busy_cnt == 0) && n < 1000) begin
            @(negedge clk);
            n++;
        end
        repeat (4) @(negedge clk);
    endtask

    task automatic test_reset();
        bus.wr_en = 1'b0;
        bus.wr_data = 8'h00;
        man_ready = 1'b0;
        #1 rst_n = 1'b0;
        repeat (3) @(negedge clk);
        checks++;
        if ({bus.count, bus.empty, bus.full, bus.overflow, bus.tx_start, bus.tx_data}
            !== {5'd0, 1'b1, 1'b0, 1'b0, 1'b0, 8'h00})
            $display("FAIL reset_state got cnt=%0d e=%b f=%b o=%b s=%b d=%h", bus.count,
                     bus.empty, bus.full, bus.overflow, bus.tx_start, bus.tx_data);
        else passed++;
        rst_n = 1'b1;
        @(negedge clk);
    endtask

    task automatic test_single();
        man_ready = 1'b1;
        @(negedge clk);
        bus.wr_en = 1'b1;
        bus.wr_data = 8'h43;
        @(negedge clk);
        bus.wr_en = 1'b0;
        checks++;
        if ({bus.count, bus.empty, bus.tx_start} !== {5'd1, 1'b0, 1'b0})
            $display("FAIL single_after_push got cnt=%0d e=%b s=%b want 1 0 0",
                     bus.count, bus.empty, bus.tx_start);
        else passed++;
        @(negedge clk);
        checks++;
        if ({bus.tx_start, bus.tx_data} !== {1'b1, 8'h43})
            $display("FAIL single_start got s=%b d=%h want 1 43", bus.tx_start, bus.tx_data);
        else passed++;
        checks++;
        if ({bus.count, bus.empty} !== {5'd0, 1'b1})
            $display("FAIL single_drained got cnt=%0d e=%b want 0 1", bus.count, bus.empty);
        else passed++;
        man_ready = 1'b0;
        @(negedge clk);
        checks++;
        if (bus.tx_start !== 1'b0)
            $display("FAIL single_pulse_width got s=%b want 0", bus.tx_start);
        else passed++;
        man_ready = 1'b1;
        repeat (3) @(negedge clk);
    endtask

    task automatic test_hello();
        logic [7:0] msg [5] = '{8'h68, 8'h65, 8'h6c, 8'h6c, 8'h6f};
        int base = rx_q.size();
        int v0 = viol;
        int n = 0;
        busy_len = 100;
        model_en = 1'b1;
        for (int i = 0; i < 5; i++) begin
            bus.wr_en = 1'b1;
            bus.wr_data = msg[i];
            @(negedge clk);
        end
        bus.wr_en = 1'b0;
        while (rx_q.size() < base + 5 && n < 2000) begin
            @(negedge clk);
            n++;
        end
        checks++;
        if (rx_q.size() != base + 5)
            $display("FAIL hello_count got %0d starts want 5", rx_q.size() - base);
        else passed++;
        for (int i = 0; i < 5 && base + i < rx_q.size(); i++) begin
            checks++;
            if (rx_q[base+i] !== msg[i])
                $display("FAIL hello_byte%0d got %h want %h", i, rx_q[base+i], msg[i]);
            else passed++;
        end
        wait_model_idle();
        checks++;
        if (viol != v0) $display("FAIL hello_start_while_busy got %0d want 0", viol - v0);
        else passed++;
    endtask

    task automatic test_overflow();
        int base;
        int n = 0;
        model_en = 1'b0;
        man_ready = 1'b0;
        for (int i = 0; i < 17; i++) begin
            bus.wr_en = 1'b1;
            bus.wr_data = 8'(8'h10 + i);
            @(negedge clk);
            if (i == 15) begin
                checks++;
                if ({bus.full, bus.count, bus.overflow} !== {1'b1, 5'd16, 1'b0})
                    $display("FAIL ovf_full16 got f=%b cnt=%0d o=%b want 1 16 0",
                             bus.full, bus.count, bus.overflow);
                else passed++;
            end
        end
        bus.wr_en = 1'b0;
        checks++;
        if ({bus.overflow, bus.count} !== {1'b1, 5'd16})
            $display("FAIL ovf_drop got o=%b cnt=%0d want 1 16", bus.overflow, bus.count);
        else passed++;
        base = rx_q.size();
        busy_len = 3;
        model_en = 1'b1;
        while (rx_q.size() < base + 16 && n < 1000) begin
            @(negedge clk);
            n++;
        end
        wait_model_idle();
        checks++;
        if (rx_q.size() != base + 16)
            $display("FAIL ovf_drain_count got %0d want 16", rx_q.size() - base);
        else passed++;
        for (int i = 0; i < 16 && base + i < rx_q.size(); i++) begin
            checks++;
            if (rx_q[base+i] !== 8'(8'h10 + i))
                $display("FAIL ovf_byte%0d got %h want %h", i, rx_q[base+i], 8'(8'h10 + i));
            else passed++;
        end
        checks++;
        if ({bus.overflow, bus.empty} !== 2'b11)
            $display("FAIL ovf_sticky got o=%b e=%b want 1 1", bus.overflow, bus.empty);
        else passed++;
    endtask

    task automatic test_wrap();
        int base;
        int nxt = 0;
        int maxc = 0;
        int n = 0;
        int v0 = viol;
        model_en = 1'b0;
        man_ready = 1'b0;
        for (int i = 0; i < 16; i++) begin
            bus.wr_en = 1'b1;
            bus.wr_data = 8'(8'h80 + nxt);
            nxt++;
            @(negedge clk);
        end
        bus.wr_en = 1'b0;
        checks++;
        if (bus.full !== 1'b1) $display("FAIL wrap_full got %b want 1", bus.full);
        else passed++;
        base = rx_q.size();
        busy_len = 2;
        model_en = 1'b1;
        while (!(nxt == 40 && rx_q.size() >= base + 40) && n < 3000) begin
            if (nxt < 40 && !bus.full) begin
                bus.wr_en = 1'b1;
                bus.wr_data = 8'(8'h80 + nxt);
                nxt++;
            end else begin
                bus.wr_en = 1'b0;
            end
            @(negedge clk);
            if (int'(bus.count) > maxc) maxc = int'(bus.count);
            n++;
        end
        bus.wr_en = 1'b0;
        wait_model_idle();
        checks++;
        if (rx_q.size() != base + 40)
            $display("FAIL wrap_count got %0d want 40", rx_q.size() - base);
        else passed++;
        for (int i = 0; i < 40 && base + i < rx_q.size(); i++) begin
            checks++;
            if (rx_q[base+i] !== 8'(8'h80 + i))
                $display("FAIL wrap_byte%0d got %h want %h", i, rx_q[base+i], 8'(8'h80 + i));
            else passed++;
        end
        checks++;
        if (maxc > 16) $display("FAIL wrap_maxcount got %0d want <=16", maxc);
        else passed++;
        checks++;
        if (viol != v0) $display("FAIL wrap_start_while_busy got %0d want 0", viol - v0);
        else passed++;
    endtask

    task automatic test_timeout();
        int n = 0;
        model_en = 1'b0;
        man_ready = 1'b1;
        repeat (2) @(negedge clk);
        bus.wr_en = 1'b1;
        bus.wr_data = 8'hA5;
        @(negedge clk);
        bus.wr_data = 8'h5A;
        @(negedge clk);
        bus.wr_en = 1'b0;
        while (!bus.tx_start && n < 10) begin
            @(negedge clk);
            n++;
        end
        checks++;
        if ({bus.tx_start, bus.tx_data, bus.count} !== {1'b1, 8'hA5, 5'd1})
            $display("FAIL tmo_first_start got s=%b d=%h cnt=%0d want 1 a5 1",
                     bus.tx_start, bus.tx_data, bus.count);
        else passed++;
        n = 0;
        do begin
            @(negedge clk);
            n++;
        end while (!bus.tx_start && n < 40);
        checks++;
        if (n != 15) $display("FAIL tmo_interval got %0d cycles want 15", n);
        else passed++;
        checks++;
        if ({bus.tx_start, bus.tx_data, bus.count} !== {1'b1, 8'hA5, 5'd1})
            $display("FAIL tmo_reissue got s=%b d=%h cnt=%0d want 1 a5 1",
                     bus.tx_start, bus.tx_data, bus.count);
        else passed++;
        man_ready = 1'b0;
        @(negedge clk);
        man_ready = 1'b1;
        n = 0;
        while (!bus.tx_start && n < 10) begin
            @(negedge clk);
            n++;
        end
        checks++;
        if ({bus.tx_start, bus.tx_data, bus.count} !== {1'b1, 8'h5A, 5'd0})
            $display("FAIL tmo_next_byte got s=%b d=%h cnt=%0d want 1 5a 0",
                     bus.tx_start, bus.tx_data, bus.count);
        else passed++;
        man_ready = 1'b0;
        @(negedge clk);
        man_ready = 1'b1;
        repeat (3) @(negedge clk);
    endtask

    task automatic test_reset_mid();
        int n = 0;
        int early = 0;
        model_en = 1'b0;
        man_ready = 1'b1;
        bus.wr_en = 1'b1;
        bus.wr_data = 8'h01;
        @(negedge clk);
        bus.wr_en = 1'b0;
        while (!bus.tx_start && n < 10) begin
            @(negedge clk);
            n++;
        end
        man_ready = 1'b0;
        for (int i = 2; i <= 4; i++) begin
            bus.wr_en = 1'b1;
            bus.wr_data = 8'(i);
            @(negedge clk);
        end
        bus.wr_en = 1'b0;
        checks++;
        if ({bus.count, bus.tx_start} !== {5'd3, 1'b0})
            $display("FAIL rmid_queued got cnt=%0d s=%b want 3 0", bus.count, bus.tx_start);
        else passed++;
        rst_n = 1'b0;
        #1;
        checks++;
        if ({bus.count, bus.empty, bus.full, bus.overflow, bus.tx_start, bus.tx_data}
            !== {5'd0, 1'b1, 1'b0, 1'b0, 1'b0, 8'h00})
            $display("FAIL rmid_async_reset got cnt=%0d e=%b f=%b o=%b s=%b d=%h", bus.count,
                     bus.empty, bus.full, bus.overflow, bus.tx_start, bus.tx_data);
        else passed++;
        repeat (2) @(negedge clk);
        rst_n = 1'b1;
        bus.wr_en = 1'b1;
        bus.wr_data = 8'h77;
        @(negedge clk);
        bus.wr_en = 1'b0;
        for (int i = 0; i < 6; i++) begin
            @(negedge clk);
            if (bus.tx_start) early++;
        end
        checks++;
        if (early != 0) $display("FAIL rmid_start_while_not_ready got %0d want 0", early);
        else passed++;
        man_ready = 1'b1;
        n = 0;
        while (!bus.tx_start && n < 10) begin
            @(negedge clk);
            n++;
        end
        checks++;
        if ({bus.tx_start, bus.tx_data, n} !== {1'b1, 8'h77, 32'd1})
            $display("FAIL rmid_first_start got s=%b d=%h lat=%0d want 1 77 1",
                     bus.tx_start, bus.tx_data, n);
        else passed++;
        man_ready = 1'b0;
        @(negedge clk);
        man_ready = 1'b1;
        repeat (3) @(negedge clk);
    endtask

    task automatic test_no_double();
        checks++;
        if (dbl != 0) $display("FAIL double_start got %0d want 0", dbl);
        else passed++;
    endtask

    initial begin
        test_reset();
        test_single();
        test_hello();
        test_overflow();
        test_wrap();
        test_timeout();
        test_reset_mid();
        test_no_double();
        $display("%0d/%0d checks passed", passed, checks);
        $finish;
    end
endmodule
